// File: rtl/ram_wr_pkg.sv
// ============================================================================
// ram_wr_pkg : shared widths and FSM state encoding for the ram_wr fill/verify block
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ram_wr_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_VERIFY = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   function automatic logic is_busy(input logic [1:0] st);
      return (st == S_FILL) || (st == S_VERIFY);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_wr_if.sv
// ============================================================================
// ram_wr_if : control, readback and status bundle of the ram_wr block
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface ram_wr_if #(
   parameter int ADDR_W = ram_wr_pkg::ADDR_W,
   parameter int DATA_W = ram_wr_pkg::DATA_W
);

   logic              start_fill;
   logic [DATA_W-1:0] seed;
   logic [DATA_W-1:0] step;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] last_word;
   logic              busy;
   logic              finished;
   logic              error;

   modport master (
      output start_fill, seed, step, rd_addr,
      input  rd_data, address, last_word, busy, finished, error
   );

   modport slave (
      input  start_fill, seed, step, rd_addr,
      output rd_data, address, last_word, busy, finished, error
   );

endinterface

`default_nettype wire

// File: rtl/ram_sdp.sv
// ============================================================================
// ram_sdp : simple dual-port synchronous RAM, one write port, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_sdp #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  wire logic              clk,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] waddr_i,
   input  wire logic [DATA_W-1:0] wdata_i,
   input  wire logic [ADDR_W-1:0] raddr_i,
   output logic      [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // No reset on array or read register so the block maps onto block RAM.
   always @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ram_wr.sv
// ============================================================================
// ram_wr  : fills a RAM with an arithmetic sequence, then reads it back and verifies it
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_wr #(
   parameter int ADDR_W = ram_wr_pkg::ADDR_W,
   parameter int DATA_W = ram_wr_pkg::DATA_W
) (
   input wire logic clk,
   input wire logic rst_a_p,
   ram_wr_if.slave  bus
);

   import ram_wr_pkg::*;

   logic [1:0]        state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0] acc_q,     acc_d;
   logic [DATA_W-1:0] seed_q,    seed_d;
   logic [DATA_W-1:0] step_q,    step_d;
   logic [DATA_W-1:0] last_q,    last_d;
   logic [DATA_W-1:0] exp_q,     exp_d;
   logic              err_q,     err_d;
   logic              rd_act_q,  rd_act_d;
   logic              cmp_vld_q, cmp_vld_d;
   logic              busy_q,    fin_q;
   logic              start_prev_q;
   logic              start_edge;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;

   assign start_edge = bus.start_fill & ~start_prev_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      acc_d     = acc_q;
      seed_d    = seed_q;
      step_d    = step_q;
      last_d    = last_q;
      exp_d     = exp_q;
      err_d     = err_q;
      rd_act_d  = rd_act_q;
      cmp_vld_d = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_edge) begin
               state_d = S_FILL;
               seed_d  = bus.seed;
               step_d  = bus.step;
               acc_d   = bus.seed;
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end
         S_FILL: begin
            last_d = acc_q;
            acc_d  = acc_q + step_q;
            addr_d = addr_q + 1'b1;
            if (&addr_q) begin
               // Restart the accumulator from the seed to regenerate expected values.
               state_d  = S_VERIFY;
               addr_d   = '0;
               acc_d    = seed_q;
               rd_act_d = 1'b1;
            end
         end
         S_VERIFY: begin
            if (rd_act_q) begin
               cmp_vld_d = 1'b1;
               exp_d     = acc_q;
               acc_d     = acc_q + step_q;
               if (&addr_q) rd_act_d = 1'b0;
               else         addr_d   = addr_q + 1'b1;
            end
            if (cmp_vld_q) begin
               if (ram_rdata != exp_q) err_d = 1'b1;
               if (!rd_act_q) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_a_p) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         acc_q        <= '0;
         seed_q       <= '0;
         step_q       <= '0;
         last_q       <= '0;
         exp_q        <= '0;
         err_q        <= 1'b0;
         rd_act_q     <= 1'b0;
         cmp_vld_q    <= 1'b0;
         busy_q       <= 1'b0;
         fin_q        <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         acc_q        <= acc_d;
         seed_q       <= seed_d;
         step_q       <= step_d;
         last_q       <= last_d;
         exp_q        <= exp_d;
         err_q        <= err_d;
         rd_act_q     <= rd_act_d;
         cmp_vld_q    <= cmp_vld_d;
         busy_q       <= is_busy(state_d);
         fin_q        <= (state_d == S_DONE);
         start_prev_q <= bus.start_fill;
      end
   end

   assign ram_we    = (state_q == S_FILL) & ~rst_a_p;
   assign ram_raddr = busy_q ? addr_q : bus.rd_addr;

   ram_sdp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (addr_q),
      .wdata_i (acc_q),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign bus.rd_data   = ram_rdata;
   assign bus.address   = addr_q;
   assign bus.last_word = last_q;
   assign bus.busy      = busy_q;
   assign bus.finished  = fin_q;
   assign bus.error     = err_q;

endmodule

`default_nettype wire

// File: doc/ram_wr.md
RAM_WR -- requirements
Module: ram_wr

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width (depth 2^ADDR_W = 256).
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_a_p  input  1  reset, synchronous, active-high.
REQ-005 start_fill  input  1  level request (board drives ~KEY); rising edge starts a fill+verify run.
REQ-006 seed  input  DATA_W  value written at address 0; sampled on the start edge.
REQ-007 step  input  DATA_W  increment between consecutive words; sampled on the start edge.
REQ-008 rd_addr  input  ADDR_W  external readback address, honoured only in IDLE/DONE.
REQ-009 rd_data  output  DATA_W  RAM word at rd_addr, 1-cycle read latency.
REQ-010 address  output  ADDR_W  address currently written/verified (for HEX display).
REQ-011 last_word  output  DATA_W  last word written.
REQ-012 busy  output  1  high in FILL and VERIFY.
REQ-013 finished  output  1  high in DONE.
REQ-014 error  output  1  sticky; high if any verify compare mismatched in the current run.

Function
REQ-015 FSM states IDLE, FILL, VERIFY, DONE; only transitions IDLE->FILL, DONE->FILL, FILL->VERIFY, VERIFY->DONE, any->IDLE on reset.
REQ-016 Start edge = start_fill high this cycle and low the previous cycle (registered previous value); a held-high level shall not restart.
REQ-017 Start edge in IDLE or DONE: latch seed/step, clear error and finished, address 0, enter FILL on the same edge.
REQ-018 Start edge in FILL or VERIFY shall be ignored.
REQ-019 FILL: one write per cycle, word[i] = (seed + i*step) mod 2^DATA_W, i = 0..255, computed by running accumulator (no multiplier).
REQ-020 last_word and address shall update with each write; after the 255th address FILL shall go to VERIFY with no wrap to a 257th write.
REQ-021 VERIFY: issue reads at addresses 0..255, one per cycle; compare each returned word one cycle later to a regenerated expected value.
REQ-022 Any mismatch shall set error; error remains set until next start edge or reset.
REQ-023 After the 256th compare FSM shall enter DONE; finished shall rise exactly 513 clock edges after the edge that sampled the start edge.
REQ-024 While busy, the internal FSM owns the RAM read port; rd_data value is don't-care.
REQ-025 step = 0 shall fill all 256 words with seed; arithmetic overflow shall wrap modulo 2^DATA_W silently.
REQ-026 Reset asserted mid-run shall abort to IDLE on that edge; RAM contents are not cleared.

Reset
REQ-027 On rst_a_p: state IDLE, address 0, last_word 0, busy 0, finished 0, error 0, latched seed/step 0, start-edge register 0.
REQ-028 rd_data is not reset; RAM array has no reset.

Structure
REQ-029 Shared package ram_wr_pkg shall hold ADDR_W, DATA_W, DEPTH and the FSM state encoding constants.
REQ-030 One sub-module ram_sdp: simple dual-port synchronous RAM, DEPTH x DATA_W, one write port, one registered read port, inferable as MAX10 M9K.
REQ-031 Read-port address mux (FSM vs rd_addr) and accumulators live in ram_wr; no combinational path from inputs to outputs except none (all outputs registered).

Verification
REQ-032 seed=0x0000, step=0x0001, start pulse -> busy 1 next cycle; finished 1 after 513 edges; rd_addr 0x00/0x7F/0xFF -> rd_data 0x0000/0x007F/0x00FF; error 0.
REQ-033 seed=0xFFF0, step=0x0010 -> word[1]=0x0000, word[255]=0x0FE0 (wrap), last_word 0x0FE0, error 0.
REQ-034 step=0, seed=0xA5A5 -> all 256 addresses read 0xA5A5; start held high 2000 cycles -> exactly one run.
REQ-035 Second start pulse at cycle 100 of a run -> ignored, finished still at edge 513; start in DONE with new seed=0x1234 -> reruns, word[0]=0x1234.
REQ-036 Reset asserted at FILL address 0x40 -> next cycle IDLE, busy 0, address 0, finished 0; RAM locations 0x00-0x3F retain written values.
REQ-037 Force one RAM write corruption (bench backdoor at address 0x10 during VERIFY before its read) -> error 1 in DONE, finished 1.
